cfu_simd_mac: RTL and testbench
===============================

# cfu_simd_mac

Parametrised SIMD multiply-accumulate custom function unit on the CPU's CFU command/response bus. Each command splits the two 32-bit operands into signed lanes, adds a programmable input offset to the lanes of operand 0, multiplies lane-wise, sums the products and adds the sum into one entry of a small accumulator bank. The unit also provides offset programming and accumulator read, write and clear. It is a two-stage pipelined design with one command outstanding, and it serves quantised convolution and fully-connected inner loops.

## Interface
- ELEM_W, 8, lane width in bits; must be 8 or 16; LANES = 32/ELEM_W
- NUM_ACC, 4, accumulator bank depth; power of two, 1..8
- ACC_W, 32, accumulator width; fixed at 32 because the response is 32 bits
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_payload_function_id  in  10  [2:0] = funct3 opcode, [9:3] = funct7; accumulator index sel = funct7[log2(NUM_ACC)-1:0], upper bits ignored
- cmd_payload_inputs_0  in  32  operand A
- cmd_payload_inputs_1  in  32  operand B
- rsp_valid  out  1  response valid, registered
- rsp_ready  in  1  CPU accepts the response
- rsp_payload_outputs_0  out  32  result, registered

## Operation
- Opcodes (funct3):
  - 0 MAC: acc[sel] += S; returns the new acc[sel].
  - 1 SETOFF: offset <= A[ELEM_W:0], interpreted as signed ELEM_W+1 bits; returns 0.
  - 2 READ: returns acc[sel].
  - 3 CLEAR: returns the old acc[sel]; acc[sel] <= 0.
  - 4 WRITE: acc[sel] <= A; returns A.
  - 5..7: return 0; no state change.
- Lane i is bits [i*ELEM_W +: ELEM_W], signed.
- Per lane: a_i = sext(A_i) + offset, computed at ELEM_W+2 bits. p_i = a_i * sext(B_i), computed at 2*ELEM_W+2 bits, with no truncation.
- S = sum of all p_i, sign-extended to ACC_W.
- Default accumulation: wrap modulo 2^32, two's complement.
- State machine: IDLE -> EXEC on accept. EXEC -> RESP unconditionally. RESP -> IDLE on rsp_ready, or RESP -> EXEC if a new command is accepted in the same cycle.
- EXEC registers the lane products, the opcode and sel. The transition to RESP performs the accumulate or bank update and loads rsp_payload_outputs_0.
- Only one command is in flight, so there are no read-after-write hazards between consecutive commands.
- Reset values: rsp_valid 0, rsp_payload_outputs_0 0, all accumulators 0, offset 0, state IDLE.
- Reset mid-operation discards the in-flight command: no accumulator update and no response.

## Timing
- Command accepted in cycle T; rsp_valid rises at T+2. Latency is 2 for every opcode.
- cmd_ready = (state == IDLE) || (state == RESP && rsp_ready). It is combinational from state and rsp_ready.
- Back-to-back throughput is one command per 2 cycles when rsp_ready is held high.
- rsp_valid and rsp_payload_outputs_0 hold stable until rsp_valid && rsp_ready. rsp_valid deasserts the following cycle unless a new response is due.
- Operands are sampled only in the accept cycle. Payload changes after acceptance have no effect.
- cmd_valid with cmd_ready low is ignored. The source must hold the command; the unit never drops an offered command.

## Configuration
- CFU_MAC_SATURATE_EN defined: MAC and WRITE results clamp to the range [0x80000000, 0x7FFFFFFF].
  - The MAC sum is computed at 33 bits and then clamped.
  - WRITE is unaffected, because A is already 32 bits.
- CFU_MAC_SATURATE_EN undefined: MAC wraps modulo 2^32. No saturation logic is present.

## Test plan
- Reset, then READ acc0..acc3: all return 0, each with rsp_valid exactly 2 cycles after accept, and cmd_ready is high in IDLE.
- With ELEM_W=8, offset 0, MAC sel0 A=0x01020304 B=0x01010101 -> returns 10. Repeating the same MAC -> returns 20.
- SETOFF A=128, then MAC sel1 A=0x01020304 B=0x01010101 -> returns 522. Then WRITE sel1 1000, then the same MAC -> returns 1522.
- Hold rsp_ready low for 5 cycles after a response:
  - the payload stays stable;
  - cmd_ready stays low;
  - a command offered during the stall is accepted in the rsp_ready cycle and responds 2 cycles later.
- Saturation: offset 0, WRITE sel2 0x7FFFFFF0, then MAC sel2 A=B=0x7F7F7F7F. The response is 0x8000FBF4 without the macro and 0x7FFFFFFF with CFU_MAC_SATURATE_EN.
- Assert reset in the EXEC cycle of a MAC on sel3 that has a nonzero result. No response appears, acc3 reads back 0, and an opcode 6 command then returns 0.

Source files
------------

// File: rtl/cfu_simd_mac.sv
// SIMD multiply-accumulate custom function unit with a small accumulator bank.
// Build macro CFU_MAC_SATURATE_EN makes MAC results clamp to signed 32-bit instead of wrapping.
module cfu_simd_mac #(
  parameter int ELEM_W  = 8,
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);
  // state | meaning
  // IDLE  | waiting for a command
  // EXEC  | lane products held; bank update happens on the way to RESP
  // RESP  | response held until rsp_ready
  localparam int LANES  = 32 / ELEM_W;
  localparam int A_W    = ELEM_W + 2;
  localparam int PROD_W = 2 * ELEM_W + 2;
  localparam int SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  localparam logic [2:0] OP_MAC    = 3'd0;
  localparam logic [2:0] OP_SETOFF = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                   state_q, state_d;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_in [LANES];
  logic [2:0]               op_q, op_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [ACC_W-1:0]         opa_q, opa_d;
  logic signed [ELEM_W:0]   offset_q, offset_d;
  logic [ACC_W-1:0]         acc_q [NUM_ACC];
  logic [ACC_W-1:0]         acc_d [NUM_ACC];
  logic                     rsp_valid_q, rsp_valid_d;
  logic [ACC_W-1:0]         rsp_data_q, rsp_data_d;

  logic                     accept;
  logic signed [ELEM_W-1:0] lane_a [LANES];
  logic signed [ELEM_W-1:0] lane_b [LANES];
  logic signed [A_W-1:0]    a_ext [LANES];
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]         acc_sel;
  logic [ACC_W-1:0]         mac_res;
  logic                     unused_fid;

  assign unused_fid = ^cmd_payload_function_id;

  assign cmd_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  // Products are formed from the live operands so they only need sampling in the accept cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_a[i]  = cmd_payload_inputs_0[i*ELEM_W +: ELEM_W];
      lane_b[i]  = cmd_payload_inputs_1[i*ELEM_W +: ELEM_W];
      a_ext[i]   = A_W'(lane_a[i]) + A_W'(offset_q);
      prod_in[i] = PROD_W'(a_ext[i]) * PROD_W'(lane_b[i]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + ACC_W'(prod_q[i]);
    end
  end

  assign acc_sel = acc_q[sel_q];

`ifdef CFU_MAC_SATURATE_EN
  logic [ACC_W:0] mac_wide;

  always_comb begin
    mac_wide = {acc_sel[ACC_W-1], acc_sel} + {sum[ACC_W-1], sum};
    if (mac_wide[ACC_W] != mac_wide[ACC_W-1]) begin
      mac_res = mac_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac_res = mac_wide[ACC_W-1:0];
    end
  end
`else
  assign mac_res = acc_sel + sum;
`endif

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    op_d        = op_q;
    sel_d       = sel_q;
    opa_d       = opa_q;
    offset_d    = offset_q;
    acc_d       = acc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept) begin
      state_d = EXEC;
      prod_d  = prod_in;
      op_d    = cmd_payload_function_id[2:0];
      sel_d   = (NUM_ACC > 1) ? cmd_payload_function_id[3 +: SEL_W] : '0;
      opa_d   = cmd_payload_inputs_0;
    end

    case (state_q)
      IDLE: ;
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        case (op_q)
          OP_MAC: begin
            acc_d[sel_q] = mac_res;
            rsp_data_d   = mac_res;
          end
          OP_SETOFF: offset_d = opa_q[ELEM_W:0];
          OP_READ:   rsp_data_d = acc_sel;
          OP_CLEAR: begin
            rsp_data_d   = acc_sel;
            acc_d[sel_q] = '0;
          end
          OP_WRITE: begin
            acc_d[sel_q] = opa_q;
            rsp_data_d   = opa_q;
          end
          default: ;
        endcase
      end
      RESP: begin
        if (!accept && rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sel_q       <= '0;
      opa_q       <= '0;
      offset_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
      for (int k = 0; k < NUM_ACC; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      opa_q       <= opa_d;
      offset_q    <= offset_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Bench for cfu_simd_mac: directed vector table, stall/reset sequences, then random commands
// against an arithmetic reference model. Honours CFU_MAC_SATURATE_EN for expected MAC results.
module tb_cfu_simd_mac;
  localparam int NUM_ACC = 4;
  localparam int LANES   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  cfu_simd_mac #(.ELEM_W(8), .NUM_ACC(NUM_ACC), .ACC_W(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0   (cmd_payload_inputs_0),
    .cmd_payload_inputs_1   (cmd_payload_inputs_1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] acc_m [NUM_ACC];
  longint      off_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Reference: plain integer arithmetic over the lanes and a 4-entry bank.
  function automatic logic [31:0] model_step(input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] a, input logic [31:0] b);
    int               sel;
    longint           s;
    longint           t;
    logic signed [7:0] la;
    logic signed [7:0] lb;
    logic signed [8:0] o9;
    logic [31:0]      r;
    sel = int'(f7) % NUM_ACC;
    s = 0;
    r = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      la = a[8*i +: 8];
      lb = b[8*i +: 8];
      s += (longint'(la) + off_m) * longint'(lb);
    end
    case (f3)
      3'd0: begin
        t = longint'($signed(acc_m[sel])) + s;
`ifdef CFU_MAC_SATURATE_EN
        if (t > 64'sh7FFFFFFF) t = 64'sh7FFFFFFF;
        if (t < -64'sh80000000) t = -64'sh80000000;
`endif
        acc_m[sel] = t[31:0];
        r = acc_m[sel];
      end
      3'd1: begin
        o9 = a[8:0];
        off_m = longint'(o9);
      end
      3'd2: r = acc_m[sel];
      3'd3: begin
        r = acc_m[sel];
        acc_m[sel] = 32'h0;
      end
      3'd4: begin
        acc_m[sel] = a;
        r = a;
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Offers a command, returns the response value (left pending with rsp_ready high),
  // cycles from accept to rsp_valid, and cycles spent waiting for cmd_ready.
  task automatic do_cmd(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat,
                        output int wait_n);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {f7, f3};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    wait_n = 0;
    while (!cmd_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_payload_function_id = 10'($urandom);
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_payload_outputs_0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] exp;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          wait_n;
    logic        ok;

    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", rsp_payload_outputs_0, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int k = 0; k < 4; k++) add_vec(3'd2, 7'(k), 32'h0, 32'h0, 32'h0);
    add_vec(3'd0, 7'd0, 32'h01020304, 32'h01010101, 32'd10);
    add_vec(3'd0, 7'd0, 32'h01020304, 32'h01010101, 32'd20);
    add_vec(3'd1, 7'd0, 32'd128, 32'h0, 32'h0);
    add_vec(3'd0, 7'd1, 32'h01020304, 32'h01010101, 32'd522);
    add_vec(3'd4, 7'd1, 32'd1000, 32'h0, 32'd1000);
    add_vec(3'd0, 7'd1, 32'h01020304, 32'h01010101, 32'd1522);
    add_vec(3'd2, 7'd0, 32'h0, 32'h0, 32'd20);
    add_vec(3'd3, 7'd0, 32'h0, 32'h0, 32'd20);
    add_vec(3'd2, 7'd0, 32'h0, 32'h0, 32'h0);
    add_vec(3'd5, 7'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    add_vec(3'd7, 7'd1, 32'h12345678, 32'h0, 32'h0);
    add_vec(3'd2, 7'h7D, 32'h0, 32'h0, 32'd1522);
    add_vec(3'd1, 7'd0, 32'h0, 32'h0, 32'h0);
    add_vec(3'd4, 7'd2, 32'h7FFFFFF0, 32'h0, 32'h7FFFFFF0);
`ifdef CFU_MAC_SATURATE_EN
    add_vec(3'd0, 7'd2, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFFF);
`else
    add_vec(3'd0, 7'd2, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h8000FBF4);
`endif
    add_vec(3'd1, 7'd0, 32'h000001FF, 32'h0, 32'h0);
    add_vec(3'd0, 7'd0, 32'h01020304, 32'hFFFFFFFF, 32'hFFFFFFFA);
    add_vec(3'd1, 7'd0, 32'h0, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      do_cmd(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, res, lat, wait_n);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_ready_wait", i), 32'(wait_n), 32'd0);
    end

    // Stall: response held with rsp_ready low while the next command waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd1, 3'd2};
    check("stall_idle_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_payload_function_id = {7'd3, 3'd4};
    cmd_payload_inputs_0 = 32'h12345678;
    @(posedge clk); #1;
    check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
    check("stall_rsp_data", rsp_payload_outputs_0, 32'd1522);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ok = rsp_valid && !cmd_ready && (rsp_payload_outputs_0 == 32'd1522);
      check($sformatf("stall_hold_c%0d", c), {rsp_valid, cmd_ready, 30'(rsp_payload_outputs_0)},
            {1'b1, 1'b0, 30'd1522});
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("stall_valid_drop", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    check("stall_second_valid", 32'(rsp_valid), 32'h1);
    check("stall_second_data", rsp_payload_outputs_0, 32'h12345678);
    @(posedge clk); #1;

    // Reset during EXEC of a MAC on sel3 (offset made nonzero first).
    do_cmd(3'd1, 7'd0, 32'd5, 32'h0, res, lat, wait_n);
    check("setoff5_data", res, 32'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd3, 3'd0};
    cmd_payload_inputs_0 = 32'h01020304;
    cmd_payload_inputs_1 = 32'h01010101;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("rst_mid_no_rsp", 32'(ok), 32'h1);
    do_cmd(3'd2, 7'd3, 32'h0, 32'h0, res, lat, wait_n);
    check("rst_mid_acc3", res, 32'h0);
    do_cmd(3'd6, 7'($urandom), $urandom, $urandom, res, lat, wait_n);
    check("rst_mid_op6", res, 32'h0);
    check("rst_mid_op6_latency", 32'(lat), 32'd2);

    for (int k = 0; k < NUM_ACC; k++) acc_m[k] = 32'h0;
    off_m = 0;
    for (int n = 0; n < 300; n++) begin
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      f7 = 7'($urandom);
      a = $urandom;
      b = $urandom;
      exp = model_step(f3, f7, a, b);
      do_cmd(f3, f7, a, b, res, lat, wait_n);
      check($sformatf("rand%0d_op%0d_data", n, f3), res, exp);
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'd2);
    end
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
